// File: rtl/watch_set_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : watch_set_ctrl
//  Purpose  : Keypad time-entry controller for the 1 kHz digital watch.
//             Debounces a raw active-low 10-key keypad into single digit
//             presses, sequences six range-checked digits into HH:MM:SS (BCD)
//             and hands the result to the watch counter as a one-cycle load.
//  Ports    : clk       - 1 kHz system clock
//             rst       - synchronous active-high reset
//             keypad    - raw keys, active-low, bit i = digit i
//             set_req   - one-cycle request to start/restart entry
//             load      - one-cycle strobe, time_bcd valid with it
//             time_bcd  - {h_ten,h_one,m_ten,m_one,s_ten,s_one}
//             setting   - high while entry is in progress
//             digit_pos - index of next expected digit (0 outside entry)
//             err       - one-cycle pulse on rejected digit or timeout abort
//  Config   : WATCH_SET_TIMEOUT_EN - when defined, entry aborts after
//             TIMEOUT_CYCLES cycles without a press or set_req.
//  Revision : 1.0 - initial release
// ============================================================================
module watch_set_ctrl #(
  parameter int DEB_CYCLES     = 20,
  parameter int TIMEOUT_CYCLES = 10000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  keypad,
  input  logic        set_req,
  output logic        load,
  output logic [23:0] time_bcd,
  output logic        setting,
  output logic [2:0]  digit_pos,
  output logic        err
);

  localparam int               DEB_W      = $clog2(DEB_CYCLES + 1);
  localparam logic [DEB_W-1:0] DEB_MAX    = DEB_W'(DEB_CYCLES);
  localparam logic [DEB_W-1:0] DEB_FIRE   = DEB_W'(DEB_CYCLES - 1);
  localparam logic [3:0]       CODE_NONE  = 4'd10;
  localparam logic [3:0]       CODE_MULTI = 4'd11;

  // --------------------------------------------------------------------------
  // Input register and key decode
  // --------------------------------------------------------------------------
  logic [9:0] ksync;
  logic [3:0] n_low;
  logic [3:0] low_idx;
  logic [3:0] code;

  always_comb begin
    n_low   = 4'd0;
    low_idx = 4'd0;
    for (int i = 0; i < 10; i++) begin
      if (!ksync[i]) begin
        n_low   = n_low + 4'd1;
        low_idx = 4'(i);
      end
    end
    if (n_low == 4'd0)      code = CODE_NONE;
    else if (n_low == 4'd1) code = low_idx;
    else                    code = CODE_MULTI;
  end

  // --------------------------------------------------------------------------
  // Debounce
  // --------------------------------------------------------------------------
  typedef enum logic {DB_UP = 1'b0, DB_DOWN = 1'b1} db_state_t;

  db_state_t        db_state, db_next;
  logic [3:0]       last_code;
  logic [DEB_W-1:0] deb_cnt;
  logic             stable_fire;
  logic             press;

  // deb_cnt counts repeats of last_code; it is DEB_CYCLES-1 on the
  // (DEB_CYCLES+1)th sample of a code, one cycle after the input register,
  // which places the press 1 + DEB_CYCLES cycles after the key appears.
  // Saturation keeps the match from recurring while a code is held.
  assign stable_fire = (code == last_code) && (deb_cnt == DEB_FIRE);

  always_ff @(posedge clk) begin
    if (rst) begin
      ksync     <= 10'h3FF;
      last_code <= CODE_NONE;
      deb_cnt   <= '0;
      db_state  <= DB_UP;
    end else begin
      ksync     <= keypad;
      last_code <= code;
      if (code != last_code)    deb_cnt <= '0;
      else if (deb_cnt != DEB_MAX) deb_cnt <= deb_cnt + 1'b1;
      db_state  <= db_next;
    end
  end

  always_comb begin
    db_next = db_state;
    press   = 1'b0;
    case (db_state)
      DB_UP: begin
        // MULTI and NONE never produce a press
        if (stable_fire && (code < CODE_NONE)) begin
          db_next = DB_DOWN;
          press   = 1'b1;
        end
      end
      DB_DOWN: begin
        if (stable_fire && (code == CODE_NONE)) db_next = DB_UP;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Entry sequencer
  // --------------------------------------------------------------------------
  typedef enum logic [1:0] {
    EN_IDLE   = 2'd0,
    EN_ENTRY  = 2'd1,
    EN_COMMIT = 2'd2
  } en_state_t;

  en_state_t   en_state, en_next;
  logic [2:0]  pos, pos_next;
  logic [23:0] shadow, shadow_next;
  logic        err_next;
  logic [3:0]  limit;
  logic        timeout_hit;

`ifdef WATCH_SET_TIMEOUT_EN
  localparam int              TO_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_MAX = TO_W'(TIMEOUT_CYCLES);

  logic [TO_W-1:0] to_cnt;

  // Held at zero outside entry so every entry starts a fresh window
  always_ff @(posedge clk) begin
    if (rst)                                          to_cnt <= '0;
    else if (set_req || press || en_state != EN_ENTRY) to_cnt <= '0;
    else if (to_cnt != TO_MAX)                        to_cnt <= to_cnt + 1'b1;
  end

  assign timeout_hit = (en_state == EN_ENTRY) && (to_cnt == TO_MAX);
`else
  logic unused_timeout_cfg;
  assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
  assign timeout_hit        = 1'b0;
`endif

  // Largest digit allowed at the current position; hours cap at 23
  always_comb begin
    limit = 4'd9;
    case (pos)
      3'd0:       limit = 4'd2;
      3'd1:       limit = (shadow[23:20] == 4'd2) ? 4'd3 : 4'd9;
      3'd2, 3'd4: limit = 4'd5;
      default:    limit = 4'd9;
    endcase
  end

  always_comb begin
    en_next     = en_state;
    pos_next    = pos;
    shadow_next = shadow;
    err_next    = 1'b0;
    case (en_state)
      EN_IDLE: begin
        if (set_req) begin
          en_next     = EN_ENTRY;
          pos_next    = 3'd0;
          shadow_next = 24'd0;
        end
      end
      EN_ENTRY: begin
        if (set_req) begin
          pos_next    = 3'd0;
          shadow_next = 24'd0;
        end else if (press) begin
          if (code <= limit) begin
            for (int k = 0; k < 6; k++) begin
              if (pos == 3'(k)) shadow_next[(5-k)*4 +: 4] = code;
            end
            pos_next = pos + 3'd1;
            if (pos == 3'd5) en_next = EN_COMMIT;
          end else begin
            err_next = 1'b1;
          end
        end else if (timeout_hit) begin
          en_next  = EN_IDLE;
          err_next = 1'b1;
        end
      end
      EN_COMMIT: en_next = EN_IDLE;
      default:   en_next = EN_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they track the state
  // register; setting stays high through COMMIT and drops after the load.
  always_ff @(posedge clk) begin
    if (rst) begin
      en_state  <= EN_IDLE;
      pos       <= 3'd0;
      shadow    <= 24'd0;
      load      <= 1'b0;
      time_bcd  <= 24'd0;
      setting   <= 1'b0;
      digit_pos <= 3'd0;
      err       <= 1'b0;
    end else begin
      en_state  <= en_next;
      pos       <= pos_next;
      shadow    <= shadow_next;
      err       <= err_next;
      load      <= (en_next == EN_COMMIT);
      if (en_next == EN_COMMIT) time_bcd <= shadow_next;
      setting   <= (en_next != EN_IDLE);
      digit_pos <= (en_next == EN_ENTRY) ? pos_next : 3'd0;
    end
  end

endmodule
`default_nettype wire
